// File: rtl/tsc_cache_pkg.sv
// Shared definitions for the TSC CPU cache.
//   - default geometry (word width, number of lines, words per line)
//   - FSM state encoding used by tsc_cache
package tsc_cache_pkg;

  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_NUM_LINES  = 4;
  localparam int DEF_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/tsc_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset (clears valid bits only)
//   rd_index, rd_offset             combinational lookup of one line/word
//   rd_data, rd_tag, rd_valid       contents of the looked-up line/word
//   wr_en, wr_index, wr_offset,
//   wr_data                         synchronous single-word data write
//   tv_en, tv_index, tv_tag,
//   tv_valid                        synchronous tag/valid update of one line
module tsc_cache_array
  import tsc_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int IDX_W      = $clog2(NUM_LINES),
  parameter int OFF_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = WORD_SIZE - IDX_W - OFF_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IDX_W-1:0]     rd_index,
  input  logic [OFF_W-1:0]     rd_offset,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [TAG_W-1:0]     rd_tag,
  output logic                 rd_valid,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic [OFF_W-1:0]     wr_offset,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 tv_en,
  input  logic [IDX_W-1:0]     tv_index,
  input  logic [TAG_W-1:0]     tv_tag,
  input  logic                 tv_valid
);

  logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  // Data and tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index][wr_offset] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (tv_en) begin
      tag_q[tv_index] <= tv_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (tv_en) begin
      valid_q[tv_index] <= tv_valid;
    end
  end

  assign rd_data  = data_q[rd_index][rd_offset];
  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/tsc_cache.sv
// Direct-mapped, write-through, no-write-allocate, blocking cache for one
// TSC CPU memory port. Read hits complete combinationally; read misses
// refill a whole line word by word; every write goes through to memory.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   readM, writeM                CPU requests, held until ready=1
//   address, wdata               CPU word address / write data
//   rdata, ready                 read data, request-complete (0 = stall)
//   mem_readM, mem_writeM        memory strobes (registered)
//   mem_address, mem_wdata       memory word address / write data
//   mem_rdata, mem_ready         memory read data, one-cycle transfer-done pulse
//   num_hits, num_misses         wrapping read hit / miss counters
module tsc_cache
  import tsc_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 ready,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [WORD_SIZE-1:0] num_hits,
  output logic [WORD_SIZE-1:0] num_misses
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  state_t           state;
  logic [OFF_W-1:0] fill_cnt;
  logic             just_filled;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;

  logic [TAG_W-1:0] line_tag;
  logic             line_valid;
  logic             hit;

  logic                 wr_en;
  logic [OFF_W-1:0]     wr_offset;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 tv_en;
  logic                 tv_valid;

  assign offset = address[OFF_W-1:0];
  assign index  = address[OFF_W +: IDX_W];
  assign tag    = address[WORD_SIZE-1 -: TAG_W];
  assign hit    = line_valid && (line_tag == tag);

  assign mem_wdata = wdata;

  tsc_cache_array #(
    .WORD_SIZE  (WORD_SIZE),
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_index  (index),
    .rd_offset (offset),
    .rd_data   (rdata),
    .rd_tag    (line_tag),
    .rd_valid  (line_valid),
    .wr_en     (wr_en),
    .wr_index  (index),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .tv_en     (tv_en),
    .tv_index  (index),
    .tv_tag    (tag),
    .tv_valid  (tv_valid)
  );

  // Handshake and array-write decode. Array writes are suppressed during
  // reset so an aborted fill cannot leave a stray word or a valid line.
  always_comb begin
    ready       = 1'b0;
    mem_address = address;
    wr_en       = 1'b0;
    wr_offset   = offset;
    wr_data     = wdata;
    tv_en       = 1'b0;
    tv_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        if (writeM) begin
          wr_en = hit;
        end else if (readM) begin
          ready = hit;
          // Invalidate the victim up front so a partly refilled line never looks valid.
          tv_en = !hit;
        end else begin
          ready = 1'b1;
        end
      end
      S_FILL: begin
        mem_address = {tag, index, fill_cnt};
        wr_offset   = fill_cnt;
        wr_data     = mem_rdata;
        if (mem_ready) begin
          wr_en = 1'b1;
          if (fill_cnt == LAST_WORD) begin
            tv_en    = 1'b1;
            tv_valid = 1'b1;
          end
        end
      end
      S_WRITE: begin
        ready = mem_ready;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
    if (!reset_n) begin
      wr_en = 1'b0;
      tv_en = 1'b0;
    end
  end

  // Main FSM with registered memory strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      fill_cnt    <= '0;
      just_filled <= 1'b0;
      mem_readM   <= 1'b0;
      mem_writeM  <= 1'b0;
      num_hits    <= '0;
      num_misses  <= '0;
    end else begin
      just_filled <= 1'b0;
      case (state)
        S_IDLE: begin
          if (writeM) begin
            state      <= S_WRITE;
            mem_writeM <= 1'b1;
          end else if (readM) begin
            if (hit) begin
              // The hit that ends a refill was already counted as a miss.
              if (!just_filled) begin
                num_hits <= num_hits + 1'b1;
              end
            end else begin
              num_misses <= num_misses + 1'b1;
              fill_cnt   <= '0;
              state      <= S_FILL;
              mem_readM  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == LAST_WORD) begin
              state       <= S_IDLE;
              mem_readM   <= 1'b0;
              just_filled <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            state      <= S_IDLE;
            mem_writeM <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          mem_readM  <= 1'b0;
          mem_writeM <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tsc_cache.sv
module tb_tsc_cache;

  logic        clk;
  logic        reset_n;
  logic        readM, writeM;
  logic [15:0] address, wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        mem_readM, mem_writeM;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] num_hits, num_misses;

  tsc_cache dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .readM       (readM),
    .writeM      (writeM),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .mem_readM   (mem_readM),
    .mem_writeM  (mem_writeM),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .num_hits    (num_hits),
    .num_misses  (num_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: initial content is addr ^ 0xA5A5; mem_ready pulses
  // 2 cycles after the strobe rises (3 cycles per transfer).
  logic [15:0] mem [0:1023];
  int          wait_cnt;

  always @(posedge clk) begin
    if ((mem_readM || mem_writeM) && !mem_ready) begin
      if (wait_cnt == 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_address[9:0]];
        if (mem_writeM) mem[mem_address[9:0]] <= mem_wdata;
        wait_cnt  <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      wait_cnt  <= 0;
    end
  end

  // Scoreboards
  typedef struct {
    logic        is_read;
    logic [15:0] data;
    int          stalls;
    int          id;
  } cpu_exp_t;

  typedef struct {
    logic        is_write;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int stall_cnt = 0;
  always @(negedge clk) begin
    cpu_exp_t e;
    if (!reset_n) begin
      stall_cnt = 0;
    end else if (readM || writeM) begin
      if (!ready) begin
        stall_cnt++;
      end else begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected_ready: got ready=1 expected no completion");
        end else begin
          e = cpu_q.pop_front();
          if (e.is_read) chk($sformatf("cpu_rdata[%0d]", e.id), {16'h0, rdata}, {16'h0, e.data});
          chk($sformatf("cpu_stalls[%0d]", e.id), stall_cnt, e.stalls);
        end
        stall_cnt = 0;
      end
    end
  end

  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    mem_exp_t m;
    logic strobe;
    strobe = mem_readM | mem_writeM;
    if (reset_n) begin
      if (strobe && !prev_strobe) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected_strobe: got rd=%0b wr=%0b addr=%h expected none",
                   mem_readM, mem_writeM, mem_address);
        end
      end
      if (strobe && mem_ready && mem_q.size() > 0) begin
        m = mem_q.pop_front();
        chk("mem_is_write", {31'h0, mem_writeM}, {31'h0, m.is_write});
        chk("mem_is_read", {31'h0, mem_readM}, {31'h0, !m.is_write});
        chk("mem_address", {16'h0, mem_address}, {16'h0, m.addr});
        if (m.is_write) chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, m.data});
      end
    end
    prev_strobe = strobe;
  end

  task automatic exp_fill(input logic [15:0] base);
    for (int i = 0; i < 4; i++) mem_q.push_back('{1'b0, base + 16'(i), 16'h0});
  endtask

  task automatic exp_mwrite(input logic [15:0] a, input logic [15:0] d);
    mem_q.push_back('{1'b1, a, d});
  endtask

  int req_id = 0;
  task automatic cpu_req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_data, input int exp_stalls);
    int n;
    cpu_q.push_back('{!wr, exp_data, exp_stalls, req_id});
    req_id++;
    @(posedge clk); #1;
    readM = !wr; writeM = wr; address = a; wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 200);
    if (!ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no ready after %0d cycles expected ready", n);
    end
    @(posedge clk); #1;
    readM = 1'b0; writeM = 1'b0;
  endtask

  task automatic chk_counters(input string name, input logic [15:0] h, input logic [15:0] m);
    @(negedge clk);
    chk({name, "_hits"}, {16'h0, num_hits}, {16'h0, h});
    chk({name, "_misses"}, {16'h0, num_misses}, {16'h0, m});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem_ready = 1'b0; mem_rdata = '0; wait_cnt = 0;
    reset_n = 1'b0; readM = 1'b0; writeM = 1'b0; address = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'd1);
    chk("rst_mem_readM", {31'h0, mem_readM}, 32'd0);
    chk("rst_mem_writeM", {31'h0, mem_writeM}, 32'd0);
    chk_counters("rst", 16'd0, 16'd0);

    // 1. cold read miss and refill
    exp_fill(16'h0010);
    cpu_req(1'b0, 16'h0012, 16'h0, 16'hA5B7, 13);
    chk_counters("t1", 16'd0, 16'd1);

    // 2. read hit in same line
    cpu_req(1'b0, 16'h0013, 16'h0, 16'hA5B6, 0);
    chk_counters("t2", 16'd1, 16'd1);

    // 3. write hit, then read back from cache
    exp_mwrite(16'h0011, 16'hBEEF);
    cpu_req(1'b1, 16'h0011, 16'hBEEF, 16'h0, 3);
    chk_counters("t3w", 16'd1, 16'd1);
    cpu_req(1'b0, 16'h0011, 16'h0, 16'hBEEF, 0);
    chk_counters("t3r", 16'd2, 16'd1);

    // 4. conflict misses on index 0
    exp_fill(16'h0050);
    cpu_req(1'b0, 16'h0050, 16'h0, 16'hA5F5, 13);
    exp_fill(16'h0010);
    cpu_req(1'b0, 16'h0010, 16'h0, 16'hA5B5, 13);
    chk_counters("t4", 16'd2, 16'd3);
    cpu_req(1'b0, 16'h0011, 16'h0, 16'hBEEF, 0);
    chk_counters("t4r", 16'd3, 16'd3);

    // 5. write miss (no allocate), then read it back via refill
    exp_mwrite(16'h0200, 16'h1234);
    cpu_req(1'b1, 16'h0200, 16'h1234, 16'h0, 3);
    chk_counters("t5w", 16'd3, 16'd3);
    exp_fill(16'h0200);
    cpu_req(1'b0, 16'h0200, 16'h0, 16'h1234, 13);
    chk_counters("t5r", 16'd3, 16'd4);

    // 6. reset in the middle of a fill
    mem_q.push_back('{1'b0, 16'h0034, 16'h0});
    mem_q.push_back('{1'b0, 16'h0035, 16'h0});
    @(posedge clk); #1;
    readM = 1'b1; address = 16'h0034;
    n = 0;
    while (mem_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_partial_fill_seen", mem_q.size(), 0);
    @(posedge clk); #1;
    reset_n = 1'b0; readM = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_mem_readM", {31'h0, mem_readM}, 32'd0);
    chk("t6_mem_writeM", {31'h0, mem_writeM}, 32'd0);
    chk("t6_hits", {16'h0, num_hits}, 32'd0);
    chk("t6_misses", {16'h0, num_misses}, 32'd0);
    exp_fill(16'h0200);
    cpu_req(1'b0, 16'h0200, 16'h0, 16'h1234, 13);
    chk_counters("t6a", 16'd0, 16'd1);
    exp_fill(16'h0034);
    cpu_req(1'b0, 16'h0034, 16'h0, 16'hA591, 13);
    chk_counters("t6b", 16'd0, 16'd2);

    repeat (4) @(posedge clk);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
